// File: rtl/dr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dr_pkg
// Purpose  : Shared dual-rail definitions. These are the codeword constants
//            and the per-bit decode/encode helpers used by the clocked
//            add/subtract pipeline.
// Contents : RAIL_NUM, DR_NULL/DR_0/DR_1/DR_ILL, dr_bit_t, dr_decode,
//            dr_encode
// Revision : 1.0  initial release
// ============================================================================
package dr_pkg;

    // Rails per bit, fixed by the dual-rail encoding.
    localparam int RAIL_NUM = 2;

    localparam logic [RAIL_NUM-1:0] DR_NULL = 2'b00;
    localparam logic [RAIL_NUM-1:0] DR_0    = 2'b01;
    localparam logic [RAIL_NUM-1:0] DR_1    = 2'b10;
    localparam logic [RAIL_NUM-1:0] DR_ILL  = 2'b11;

    // Decoded single bit: its logic value and whether the codeword was legal.
    typedef struct packed {
        logic val;
        logic legal;
    } dr_bit_t;

    // Codeword -> value + legality. NULL and ILL both decode as illegal.
    function automatic dr_bit_t dr_decode(input logic [RAIL_NUM-1:0] cw);
        dr_bit_t r;
        r.val   = 1'b0;
        r.legal = 1'b0;
        case (cw)
            DR_0:    begin r.val = 1'b0; r.legal = 1'b1; end
            DR_1:    begin r.val = 1'b1; r.legal = 1'b1; end
            DR_ILL:  begin r.val = 1'b0; r.legal = 1'b0; end
            default: begin r.val = 1'b0; r.legal = 1'b0; end
        endcase
        return r;
    endfunction

    // Value -> legal codeword.
    function automatic logic [RAIL_NUM-1:0] dr_encode(input logic v);
        return v ? DR_1 : DR_0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/addsub_seg_stage.sv
`default_nettype none
// ============================================================================
// Module   : addsub_seg_stage
// Purpose  : One SEG-bit slice of the pipelined adder. This stage adds
//            operand segment IDX with the incoming carry. It registers the
//            carry and the partially built sum, and forwards the full
//            operands so later stages can add the higher segments.
// Ports    : clk, rst (async, active-low), hold (freeze all state),
//            valid_in/carry_in/a_in/b_in/sum_in  -> upstream beat
//            valid_out/carry_out/a_out/b_out/sum_out <- registered beat
// Revision : 1.0  initial release
// ============================================================================
module addsub_seg_stage #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             valid_in,
    input  logic             carry_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] sum_in,
    output logic             valid_out,
    output logic             carry_out,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic [WIDTH-1:0] sum_out
);

    localparam int LO = IDX * SEG;

    logic [SEG:0]     w_seg_sum;
    logic [WIDTH-1:0] w_sum_next;

    always_comb begin
        w_seg_sum  = {1'b0, a_in[LO +: SEG]} + {1'b0, b_in[LO +: SEG]}
                   + {{SEG{1'b0}}, carry_in};
        // Lower segments arrive already summed. Only this slice is filled in.
        w_sum_next = sum_in;
        w_sum_next[LO +: SEG] = w_seg_sum[SEG-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_out <= 1'b0;
            carry_out <= 1'b0;
            a_out     <= '0;
            b_out     <= '0;
            sum_out   <= '0;
        end else if (!hold) begin
            valid_out <= valid_in;
            carry_out <= w_seg_sum[SEG];
            a_out     <= a_in;
            b_out     <= b_in;
            sum_out   <= w_sum_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/int_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : int_addsub_pipe
// Purpose  : Clocked dual-rail add/subtract with a valid/ready link.
//            Operand beats are checked for legal codewords and decoded.
//            They are then summed in STAGES carry-registered segments and
//            returned dual-rail. The result is NULL whenever no result is
//            presented. WIDTH must be a multiple of STAGES.
// Ports    : clk, rst (async, active-low)
//            in_valid/in_ready, a, b, c_in, sub   -> operand beat
//            out_valid/out_ready, s, c_out, ovf   <- result
//            err : one-cycle pulse after a rejected beat
// Revision : 1.0  initial release
// ============================================================================
module int_addsub_pipe
    import dr_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4,
    parameter bit SAT    = 1'b0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WIDTH-1:0][RAIL_NUM-1:0]   a,
    input  logic [WIDTH-1:0][RAIL_NUM-1:0]   b,
    input  logic [RAIL_NUM-1:0]              c_in,
    input  logic                             sub,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [WIDTH-1:0][RAIL_NUM-1:0]   s,
    output logic [RAIL_NUM-1:0]              c_out,
    output logic                             ovf,
    output logic                             err
);

    localparam int SEG = WIDTH / STAGES;

    logic             w_stall;
    logic             w_legal;
    logic             w_cin_val;
    logic [WIDTH-1:0] w_a_val;
    logic [WIDTH-1:0] w_b_val;
    logic             w_xfer;
    logic             r_err;

    logic [STAGES:0]            w_chain_valid;
    logic [STAGES:0]            w_chain_carry;
    logic [STAGES:0][WIDTH-1:0] w_chain_a;
    logic [STAGES:0][WIDTH-1:0] w_chain_b;
    logic [STAGES:0][WIDTH-1:0] w_chain_sum;

    logic             w_sign_a;
    logic             w_sign_b;
    logic             w_ovf_raw;
    logic [WIDTH-1:0] w_res;
    logic             w_unused;

    // ---------------------------------------------------------------- input
    always_comb begin
        dr_bit_t w_d;
        w_legal   = 1'b1;
        w_a_val   = '0;
        w_b_val   = '0;
        w_d       = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_d        = dr_decode(a[i]);
            w_a_val[i] = w_d.val;
            w_legal    = w_legal & w_d.legal;
            w_d        = dr_decode(b[i]);
            w_b_val[i] = w_d.val;
            w_legal    = w_legal & w_d.legal;
        end
        w_d       = dr_decode(c_in);
        w_cin_val = w_d.val;
        w_legal   = w_legal & w_d.legal;
    end

    // A stalled output freezes every stage, so the input link closes at once.
    assign w_stall  = out_valid & ~out_ready;
    assign in_ready = ~w_stall;
    assign w_xfer   = in_valid & in_ready;

    // A rejected beat never enters the pipe. It only raises err next cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_xfer & ~w_legal;
        end
    end
    assign err = r_err;

    // ------------------------------------------------------------- pipeline
    // Subtraction is a + ~b + c_in. B is inverted once here so that every stage
    // and the overflow check use the effective operand.
    assign w_chain_valid[0] = w_xfer & w_legal;
    assign w_chain_carry[0] = w_cin_val;
    assign w_chain_a[0]     = w_a_val;
    assign w_chain_b[0]     = sub ? ~w_b_val : w_b_val;
    assign w_chain_sum[0]   = '0;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        addsub_seg_stage #(
            .WIDTH (WIDTH),
            .SEG   (SEG),
            .IDX   (k)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .hold      (w_stall),
            .valid_in  (w_chain_valid[k]),
            .carry_in  (w_chain_carry[k]),
            .a_in      (w_chain_a[k]),
            .b_in      (w_chain_b[k]),
            .sum_in    (w_chain_sum[k]),
            .valid_out (w_chain_valid[k+1]),
            .carry_out (w_chain_carry[k+1]),
            .a_out     (w_chain_a[k+1]),
            .b_out     (w_chain_b[k+1]),
            .sum_out   (w_chain_sum[k+1])
        );
    end

    // ---------------------------------------------------- overflow / clamp
    assign w_sign_a  = w_chain_a[STAGES][WIDTH-1];
    assign w_sign_b  = w_chain_b[STAGES][WIDTH-1];
    assign w_ovf_raw = (w_sign_a == w_sign_b) &&
                       (w_chain_sum[STAGES][WIDTH-1] != w_sign_a);

    // The overflow direction follows the common operand sign. Only the sum is
    // clamped; c_out stays the raw carry.
    always_comb begin
        w_res = w_chain_sum[STAGES];
        if (SAT && w_ovf_raw) begin
            w_res = w_sign_a ? {1'b1, {(WIDTH-1){1'b0}}}
                             : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    // Only the operand sign bits matter after the last stage.
    assign w_unused = ^{w_chain_a[STAGES][WIDTH-2:0], w_chain_b[STAGES][WIDTH-2:0]};

    // ----------------------------------------------------- output encoding
    assign out_valid = w_chain_valid[STAGES];

    always_comb begin
        s     = '0;
        c_out = DR_NULL;
        ovf   = 1'b0;
        if (out_valid) begin
            for (int i = 0; i < WIDTH; i++) begin
                s[i] = dr_encode(w_res[i]);
            end
            c_out = dr_encode(w_chain_carry[STAGES]);
            ovf   = w_ovf_raw;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_int_addsub_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_int_addsub_pipe
// Purpose  : Directed, table-driven bench for int_addsub_pipe. It runs a
//            wrapping instance and a saturating instance side by side.
//            Expected values come from the vector table; a small valid/stall
//            pipeline model gives the expected timing.
// Revision : 1.0  initial release
// ============================================================================
module tb_int_addsub_pipe;
    import dr_pkg::*;

    localparam int W  = 16;
    localparam int ST = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready, in_ready_sat;
    logic [W-1:0][1:0] a, b;
    logic [1:0]        c_in;
    logic              sub;
    logic              out_valid, out_valid_sat;
    logic              out_ready;
    logic [W-1:0][1:0] s, s_sat;
    logic [1:0]        c_out, c_out_sat;
    logic              ovf, ovf_sat;
    logic              err, err_sat;

    always #5 clk = ~clk;

    int_addsub_pipe #(.WIDTH(W), .STAGES(ST), .SAT(1'b0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .c_out(c_out), .ovf(ovf), .err(err)
    );

    int_addsub_pipe #(.WIDTH(W), .STAGES(ST), .SAT(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_sat),
        .a(a), .b(b), .c_in(c_in), .sub(sub),
        .out_valid(out_valid_sat), .out_ready(out_ready),
        .s(s_sat), .c_out(c_out_sat), .ovf(ovf_sat), .err(err_sat)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        int           bad;     // 0 good, 1 a[3]=ILL, 2 b[0]=NULL
        logic [W-1:0] es;
        logic         ec;
        logic         eo;
        logic [W-1:0] es_sat;
    } vec_t;

    vec_t tbl [12];
    int   seq [$];
    int   stall_lo, stall_hi;
    int   n_checks = 0;
    int   n_err    = 0;

    function automatic logic [W-1:0][1:0] enc(input logic [W-1:0] v);
        logic [W-1:0][1:0] r;
        for (int i = 0; i < W; i++) r[i] = v[i] ? 2'b10 : 2'b01;
        return r;
    endfunction

    function automatic logic [1:0] enc1(input logic v);
        return v ? 2'b10 : 2'b01;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_beat(input int idx);
        logic [W-1:0][1:0] ta, tb;
        ta = enc(tbl[idx].a);
        tb = enc(tbl[idx].b);
        if (tbl[idx].bad == 1) ta[3] = 2'b11;
        if (tbl[idx].bad == 2) tb[0] = 2'b00;
        a    = ta;
        b    = tb;
        c_in = enc1(tbl[idx].cin);
        sub  = tbl[idx].sub;
    endtask

    // Drives seq[] back-to-back and checks every cycle. The pipeline must be
    // empty on entry. out_ready is low in cycles [stall_lo, stall_hi).
    task automatic run_seq();
        bit   mv [ST];
        int   mi [ST];
        bit   stall_m, prev_stall, err_exp, xfer;
        int   pos, cyc, inflight, top;
        logic [W-1:0][1:0] hs, hss;
        logic [1:0] hc;
        logic       ho;
        for (int k = 0; k < ST; k++) begin mv[k] = 1'b0; mi[k] = 0; end
        pos = 0; cyc = 0; inflight = 0; prev_stall = 1'b0; err_exp = 1'b0;
        hs = '0; hss = '0; hc = '0; ho = 1'b0;
        while ((pos < seq.size() || inflight != 0 || err_exp) && cyc < 200) begin
            out_ready = !(cyc >= stall_lo && cyc < stall_hi);
            #1;
            top = mi[ST-1];
            chk("out_valid", 32'(out_valid), 32'(mv[ST-1]));
            chk("out_valid_sat", 32'(out_valid_sat), 32'(mv[ST-1]));
            if (mv[ST-1]) begin
                chk("s", 32'(s), 32'(enc(tbl[top].es)));
                chk("c_out", 32'(c_out), 32'(enc1(tbl[top].ec)));
                chk("ovf", 32'(ovf), 32'(tbl[top].eo));
                chk("s_sat", 32'(s_sat), 32'(enc(tbl[top].es_sat)));
                chk("c_out_sat", 32'(c_out_sat), 32'(enc1(tbl[top].ec)));
                chk("ovf_sat", 32'(ovf_sat), 32'(tbl[top].eo));
            end else begin
                chk("s_null", 32'(s), 32'h0);
                chk("c_out_null", 32'(c_out), 32'h0);
                chk("ovf_idle", 32'(ovf), 32'h0);
            end
            stall_m = mv[ST-1] && !out_ready;
            chk("in_ready", 32'(in_ready), 32'(!stall_m));
            chk("in_ready_sat", 32'(in_ready_sat), 32'(!stall_m));
            if (prev_stall) begin
                chk("s_hold", 32'(s), 32'(hs));
                chk("s_sat_hold", 32'(s_sat), 32'(hss));
                chk("c_out_hold", 32'(c_out), 32'(hc));
                chk("ovf_hold", 32'(ovf), 32'(ho));
            end
            chk("err", 32'(err), 32'(err_exp));
            chk("err_sat", 32'(err_sat), 32'(err_exp));
            // Present the next beat (held until it transfers).
            if (pos < seq.size()) begin
                drive_beat(seq[pos]);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            xfer    = in_valid && !stall_m;
            err_exp = xfer && (tbl[seq[pos]].bad != 0);
            if (!stall_m) begin
                for (int k = ST-1; k > 0; k--) begin
                    mv[k] = mv[k-1];
                    mi[k] = mi[k-1];
                end
                mv[0] = xfer && (tbl[seq[pos]].bad == 0);
                mi[0] = xfer ? seq[pos] : 0;
            end
            if (xfer) pos++;
            inflight = 0;
            for (int k = 0; k < ST; k++) if (mv[k]) inflight++;
            prev_stall = stall_m;
            hs = s; hss = s_sat; hc = c_out; ho = ovf;
            @(posedge clk);
            #1;
            cyc++;
        end
        if (cyc >= 200) begin
            n_checks++;
            n_err++;
            $display("FAIL run_seq_timeout: got %0d cycles expected < 200", cyc);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        //              a         b         cin   sub   bad  es        ec    eo    es_sat
        tbl[0]  = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 0, 16'h0100, 1'b0, 1'b0, 16'h0100};
        tbl[1]  = '{16'h0005, 16'h0007, 1'b1, 1'b1, 0, 16'hFFFE, 1'b0, 1'b0, 16'hFFFE};
        tbl[2]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 16'h8000, 1'b0, 1'b1, 16'h7FFF};
        tbl[3]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 0, 16'h0000, 1'b1, 1'b1, 16'h8000};
        tbl[4]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 16'h0000, 1'b1, 1'b0, 16'h0000};
        tbl[5]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 0, 16'h5556, 1'b0, 1'b0, 16'h5556};
        tbl[6]  = '{16'h8000, 16'h0001, 1'b1, 1'b1, 0, 16'h7FFF, 1'b1, 1'b1, 16'h8000};
        tbl[7]  = '{16'h0000, 16'h0000, 1'b1, 1'b1, 0, 16'h0000, 1'b1, 1'b0, 16'h0000};
        tbl[8]  = '{16'h0003, 16'h0001, 1'b0, 1'b1, 0, 16'h0001, 1'b1, 1'b0, 16'h0001};
        tbl[9]  = '{16'hABCD, 16'h1111, 1'b0, 1'b0, 0, 16'hBCDE, 1'b0, 1'b0, 16'hBCDE};
        tbl[10] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 1, 16'h0000, 1'b0, 1'b0, 16'h0000};
        tbl[11] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 2, 16'h0000, 1'b0, 1'b0, 16'h0000};

        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; c_in = 2'b00; sub = 1'b0;
        stall_lo = 0; stall_hi = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_s_null", 32'(s), 32'h0);
        chk("rst_c_out_null", 32'(c_out), 32'h0);
        chk("rst_ovf", 32'(ovf), 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single beat: latency and NULL output before the result.
        seq = '{0};
        run_seq();

        // Whole good table, back to back.
        seq = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
        run_seq();

        // Six beats, out_ready low for 3 cycles mid-stream.
        seq = '{1, 2, 3, 4, 5, 6};
        stall_lo = 5; stall_hi = 8;
        run_seq();

        // Illegal beats between good neighbours.
        seq = '{5, 10, 11, 9};
        stall_lo = 0; stall_hi = 0;
        run_seq();

        // Illegal beat pending during a stall: no err until it transfers.
        seq = '{0, 1, 2, 3, 10, 5};
        stall_lo = 4; stall_hi = 7;
        run_seq();
        stall_lo = 0; stall_hi = 0;

        // Reset while three beats are in flight and the output is stalled.
        for (int i = 7; i <= 9; i++) begin
            drive_beat(i);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        #1;
        chk("pre_rst_out_valid", 32'(out_valid), 32'h1);
        chk("pre_rst_in_ready", 32'(in_ready), 32'h0);
        rst = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_out_valid_sat", 32'(out_valid_sat), 32'h0);
        chk("mid_rst_s_null", 32'(s), 32'h0);
        chk("mid_rst_c_out_null", 32'(c_out), 32'h0);
        chk("mid_rst_ovf", 32'(ovf), 32'h0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'h1);
        chk("mid_rst_err", 32'(err), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk("post_rst_no_stale", 32'(out_valid), 32'h0);
            chk("post_rst_err", 32'(err), 32'h0);
        end
        seq = '{2};
        run_seq();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
